// File: rtl/core_dmem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : core_dmem_pkg
// Purpose  : Shared constants for the core data-memory responder:
//            access-mode codes, MMIO register offsets, default MMIO base.
// Revision : 1.0 - initial release
// ============================================================================
package core_dmem_pkg;

    // Access size codes on i_RAM_mode (2'b11 is also treated as a word access)
    localparam logic [1:0] MODE_B = 2'b00;
    localparam logic [1:0] MODE_H = 2'b01;
    localparam logic [1:0] MODE_W = 2'b10;

    // Register offsets inside the 64 KiB peripheral window
    localparam logic [15:0] OFS_CYCLE = 16'h0000;
    localparam logic [15:0] OFS_KEYS  = 16'h0004;
    localparam logic [15:0] OFS_TCMP  = 16'h0008;
    localparam logic [15:0] OFS_TCTL  = 16'h000C;
    localparam logic [15:0] OFS_LED   = 16'h0010;
    localparam logic [15:0] OFS_TCNT  = 16'h0014;

    localparam logic [31:0] DEF_MMIO_BASE = 32'hFFFF_0000;

    // True when the low address bits do not match the natural alignment of the access size
    function automatic logic is_misaligned(input logic [1:0] mode, input logic [1:0] lane);
        if (mode == MODE_H) begin
            return lane[0];
        end else if (mode[1]) begin
            return (lane != 2'b00);
        end
        return 1'b0;
    endfunction

endpackage
`default_nettype wire

// File: rtl/core_dmem_timer.sv
`default_nettype none
// ============================================================================
// Module   : core_dmem_timer
// Purpose  : Interval timer for the data-memory peripheral window.
//            Counts while EN is set; on CNT==CMP it wraps to 0 and sets FLAG.
//            The irq output is FLAG qualified by EN.
// Revision : 1.0 - initial release
// ============================================================================
module core_dmem_timer (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_cmp,
    input  logic        wr_ctl,
    input  logic        wr_cnt,
    input  logic [31:0] wdata,
    output logic [31:0] cmp,
    output logic [31:0] cnt,
    output logic        en,
    output logic        flag,
    output logic        irq
);

    logic hit;

    assign hit = en && (cnt == cmp);
    assign irq = flag & en;

    // Timer state: a software CNT write beats the increment; a hardware FLAG set beats a software clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmp  <= '0;
            cnt  <= '0;
            en   <= 1'b0;
            flag <= 1'b0;
        end else begin
            if (wr_cmp) begin
                cmp <= wdata;
            end
            if (wr_ctl) begin
                en <= wdata[1];
            end
            if (wr_cnt) begin
                cnt <= wdata;
            end else if (hit) begin
                cnt <= '0;
            end else if (en) begin
                cnt <= cnt + 32'd1;
            end
            if (hit) begin
                flag <= 1'b1;
            end else if (wr_ctl && wdata[0]) begin
                flag <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/core_dmem.sv
`default_nettype none
// ============================================================================
// Module   : core_dmem
// Purpose  : Data-memory responder for the core's RAM port. Combinational
//            byte/half/word loads and edge-committed stores to an on-chip
//            RAM, plus a peripheral window (cycle counter, keys, LEDs and an
//            optional interval timer).
// Options  : CORE_DMEM_TIMER_EN - include the interval timer and o_irq.
// Revision : 1.0 - initial release
// ============================================================================
module core_dmem
    import core_dmem_pkg::*;
#(
    parameter int          ADDR_W    = 12,
    parameter logic [31:0] MMIO_BASE = DEF_MMIO_BASE
) (
    input  logic        i_CLK,
    input  logic        i_RST,
    input  logic [31:0] i_RAM_addr,
    input  logic [31:0] i_RAM_data,
    output logic [31:0] o_RAM_data,
    input  logic [1:0]  i_RAM_mode,
    input  logic        i_RAM_unsign,
    input  logic        i_RAM_w_en,
    input  logic [7:0]  i_keys,
    output logic [7:0]  o_led,
    output logic        o_irq,
    output logic        o_misalign
);

    localparam int RAM_WORDS = 1 << ADDR_W;

    logic [31:0]       ram [RAM_WORDS];
    logic [ADDR_W-1:0] word_idx;
    logic [15:0]       ofs;
    logic              in_ram;
    logic              in_mmio;
    logic              ram_we;
    logic              mmio_we;
    logic [3:0]        lane_be;
    logic [31:0]       lane_wdata;
    logic [31:0]       cycle_cnt;
    logic [7:0]        keys_meta;
    logic [7:0]        keys_sync;
    logic [31:0]       mmio_rdata;
    logic [31:0]       word_rdata;
    logic [7:0]        byte_sel;
    logic [15:0]       half_sel;

    // Misaligned accesses simply drop the low bits: the word index and the
    // register offset never look at addr[1:0]
    assign word_idx = i_RAM_addr[ADDR_W+1:2];
    assign ofs      = {i_RAM_addr[15:2], 2'b00};
    assign in_ram   = (i_RAM_addr[31:ADDR_W+2] == '0);
    assign in_mmio  = (i_RAM_addr[31:16] == MMIO_BASE[31:16]);
    assign ram_we   = i_RAM_w_en && in_ram;
    // Peripheral registers only accept full-word stores
    assign mmio_we  = i_RAM_w_en && in_mmio && i_RAM_mode[1];

    // Store lane enables and right-aligned data replicated onto every lane
    always_comb begin
        lane_be    = 4'b1111;
        lane_wdata = i_RAM_data;
        case (i_RAM_mode)
            MODE_B: begin
                lane_be    = 4'b0001 << i_RAM_addr[1:0];
                lane_wdata = {4{i_RAM_data[7:0]}};
            end
            MODE_H: begin
                lane_be    = i_RAM_addr[1] ? 4'b1100 : 4'b0011;
                lane_wdata = {2{i_RAM_data[15:0]}};
            end
            default: begin
                lane_be    = 4'b1111;
                lane_wdata = i_RAM_data;
            end
        endcase
    end

    // RAM lane writes; a store coinciding with reset is discarded
    always_ff @(posedge i_CLK) begin
        if (ram_we && !i_RST) begin
            for (int i = 0; i < 4; i++) begin
                if (lane_be[i]) begin
                    ram[word_idx][8*i +: 8] <= lane_wdata[8*i +: 8];
                end
            end
        end
    end

    // Cycle counter, key synchronizer, LED register and sticky misalign flag
    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            cycle_cnt  <= '0;
            keys_meta  <= '0;
            keys_sync  <= '0;
            o_led      <= '0;
            o_misalign <= 1'b0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
            keys_meta <= i_keys;
            keys_sync <= keys_meta;
            if (mmio_we && (ofs == OFS_LED)) begin
                o_led <= i_RAM_data[7:0];
            end
            if (is_misaligned(i_RAM_mode, i_RAM_addr[1:0])) begin
                o_misalign <= 1'b1;
            end
        end
    end

`ifdef CORE_DMEM_TIMER_EN
    logic [31:0] tmr_cmp;
    logic [31:0] tmr_cnt;
    logic        tmr_en;
    logic        tmr_flag;

    core_dmem_timer u_timer (
        .clk    (i_CLK),
        .rst    (i_RST),
        .wr_cmp (mmio_we && (ofs == OFS_TCMP)),
        .wr_ctl (mmio_we && (ofs == OFS_TCTL)),
        .wr_cnt (mmio_we && (ofs == OFS_TCNT)),
        .wdata  (i_RAM_data),
        .cmp    (tmr_cmp),
        .cnt    (tmr_cnt),
        .en     (tmr_en),
        .flag   (tmr_flag),
        .irq    (o_irq)
    );
`else
    assign o_irq = 1'b0;
`endif

    // Peripheral read mux; unknown offsets read as zero
    always_comb begin
        mmio_rdata = '0;
        case (ofs)
            OFS_CYCLE: mmio_rdata = cycle_cnt;
            OFS_KEYS:  mmio_rdata = {24'b0, keys_sync};
            OFS_LED:   mmio_rdata = {24'b0, o_led};
`ifdef CORE_DMEM_TIMER_EN
            OFS_TCMP:  mmio_rdata = tmr_cmp;
            OFS_TCTL:  mmio_rdata = {30'b0, tmr_en, tmr_flag};
            OFS_TCNT:  mmio_rdata = tmr_cnt;
`endif
            default:   mmio_rdata = '0;
        endcase
    end

    // Whole-word read from the addressed region, then lane select and extend
    always_comb begin
        word_rdata = '0;
        if (in_ram) begin
            word_rdata = ram[word_idx];
        end else if (in_mmio) begin
            word_rdata = mmio_rdata;
        end
        byte_sel   = word_rdata[{i_RAM_addr[1:0], 3'b000} +: 8];
        half_sel   = i_RAM_addr[1] ? word_rdata[31:16] : word_rdata[15:0];
        case (i_RAM_mode)
            MODE_B:  o_RAM_data = i_RAM_unsign ? {24'b0, byte_sel}
                                               : {{24{byte_sel[7]}}, byte_sel};
            MODE_H:  o_RAM_data = i_RAM_unsign ? {16'b0, half_sel}
                                               : {{16{half_sel[15]}}, half_sel};
            default: o_RAM_data = word_rdata;
        endcase
    end

endmodule
`default_nettype wire
